freq_gate_sequencer: RTL and testbench

//  Measurement sequencer for the frequency counter. It times the counting gate in the clk_in domain,

---
 rtl/freq_counter_pkg.sv | 25 ++
 rtl/freq_gate_sequencer_timer.sv | 28 ++
 rtl/freq_gate_sequencer.sv | 154 +++++++++++++++
 tb/tb_freq_gate_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/freq_counter_pkg.sv
// Shared types and gate-length helper for the frequency counter measurement sequencer.
package freq_counter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GATE,
    SETTLE,
    LATCH,
    REFRESH
  } fgs_state_t;

  typedef logic [1:0] gate_sel_t;

  // Gate length in clk_in cycles: sel steps the base period by decades, 1/100 .. x10.
  function automatic int unsigned gate_len(input int unsigned base, input gate_sel_t sel);
    case (sel)
      2'd0:    gate_len = base / 100;
      2'd1:    gate_len = base / 10;
      2'd2:    gate_len = base;
      default: gate_len = base * 10;
    endcase
  endfunction

endpackage

// File: rtl/freq_gate_sequencer_timer.sv
// Loadable down-counter shared by the CLEAR, GATE and SETTLE phases; done is high while it rests at zero.
module gate_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state is written with <= so every flop samples the same pre-edge values.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // A phase loaded with L-1 therefore lasts exactly L cycles before done is seen.
  assign done = (count == '0);

endmodule

// File: rtl/freq_gate_sequencer.sv
// Measurement sequencer: times the counting gate, freezes the BCD counter, snapshots it and
// hands the snapshot to the display streamer with a request/ready handshake.
module freq_gate_sequencer
  import freq_counter_pkg::*;
#(
  parameter int unsigned DIGITS_NUM    = 6,
  parameter int unsigned GATE_BASE     = 1000000,
  parameter int unsigned CLEAR_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    enable_in,
  input  logic [1:0]              gate_sel_in,
  input  logic [4*DIGITS_NUM-1:0] cnt_digits_in,
  input  logic                    cnt_ovf_in,
  output logic                    cnt_reset_out,
  output logic                    cnt_enable_out,
  output logic [4*DIGITS_NUM-1:0] digits_out,
  output logic                    overflow_out,
  output logic [1:0]              range_out,
  output logic                    refresh_stb_out,
  input  logic                    streamer_ready_in,
  output logic                    gate_active_out
);

  localparam int unsigned TIMER_W = $clog2(10 * GATE_BASE + 1);

  typedef logic [TIMER_W-1:0] tcount_t;

  localparam tcount_t CLEAR_LOAD  = tcount_t'(CLEAR_CYCLES - 1);
  localparam tcount_t SETTLE_LOAD = tcount_t'(SETTLE_CYCLES - 1);

  fgs_state_t state;
  fgs_state_t state_next;
  gate_sel_t  sel_q;
  logic       timer_load;
  tcount_t    timer_val;
  logic       timer_done;
  logic       sample_sel;
  logic       latch_result;

  gate_timer #(
    .WIDTH(TIMER_W)
  ) u_gate_timer (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no branch can leave one unassigned (no latch).
    state_next   = state;
    timer_load   = 1'b0;
    timer_val    = '0;
    sample_sel   = 1'b0;
    latch_result = 1'b0;

    case (state)
      IDLE: begin
        if (enable_in) begin
          state_next = CLEAR;
          timer_load = 1'b1;
          timer_val  = CLEAR_LOAD;
          sample_sel = 1'b1;
        end
      end

      CLEAR: begin
        if (timer_done) begin
          state_next = GATE;
          timer_load = 1'b1;
          timer_val  = tcount_t'(gate_len(GATE_BASE, sel_q) - 1);
        end
      end

      GATE: begin
        if (timer_done) begin
          state_next = SETTLE;
          timer_load = 1'b1;
          timer_val  = SETTLE_LOAD;
        end
      end

      // The timer parks at zero, so a busy streamer simply extends the frozen period.
      SETTLE: begin
        if (timer_done && streamer_ready_in) begin
          state_next = LATCH;
        end
      end

      LATCH: begin
        state_next   = REFRESH;
        latch_result = 1'b1;
      end

      REFRESH: begin
        if (!streamer_ready_in) begin
          if (enable_in) begin
            state_next = CLEAR;
            timer_load = 1'b1;
            timer_val  = CLEAR_LOAD;
            sample_sel = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Counter controls and strobe are decoded from the next state into flops, so they are glitch-free
  // and line up exactly with the state they describe.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state           <= IDLE;
      cnt_reset_out   <= 1'b1;
      cnt_enable_out  <= 1'b0;
      refresh_stb_out <= 1'b0;
    end else begin
      state           <= state_next;
      cnt_reset_out   <= (state_next == IDLE) || (state_next == CLEAR);
      cnt_enable_out  <= (state_next == GATE);
      refresh_stb_out <= (state_next == REFRESH);
    end
  end

  // NOTE: the result register is reset on purpose: a cleared display is how a pending refresh is abandoned.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      sel_q        <= '0;
      digits_out   <= '0;
      overflow_out <= 1'b0;
      range_out    <= '0;
    end else begin
      if (sample_sel) begin
        sel_q <= gate_sel_in;
      end
      // Counter inputs cross domains unsynchronised; they are frozen by the time LATCH samples them.
      if (latch_result) begin
        digits_out   <= cnt_digits_in;
        overflow_out <= cnt_ovf_in;
        range_out    <= sel_q;
      end
    end
  end

  assign gate_active_out = cnt_enable_out;

endmodule

// File: tb/tb_freq_gate_sequencer.sv
// Self-checking bench: phase lengths and displayed results come from a cycle-count model of the sequencer.
module tb_freq_gate_sequencer;
  import freq_counter_pkg::*;

  localparam int DIGITS_NUM    = 6;
  localparam int GATE_BASE     = 1000;
  localparam int CLEAR_CYCLES  = 2;
  localparam int SETTLE_CYCLES = 4;

  logic                    clk_in = 1'b0;
  logic                    reset_in;
  logic                    enable_in;
  logic [1:0]              gate_sel_in;
  logic [4*DIGITS_NUM-1:0] cnt_digits_in;
  logic                    cnt_ovf_in;
  logic                    cnt_reset_out;
  logic                    cnt_enable_out;
  logic [4*DIGITS_NUM-1:0] digits_out;
  logic                    overflow_out;
  logic [1:0]              range_out;
  logic                    refresh_stb_out;
  logic                    streamer_ready_in;
  logic                    gate_active_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected content of the display registers.
  logic [23:0] exp_digits = '0;
  logic        exp_ovf    = 1'b0;
  logic [1:0]  exp_range  = '0;

  always #5 clk_in = ~clk_in;

  freq_gate_sequencer #(
    .DIGITS_NUM    (DIGITS_NUM),
    .GATE_BASE     (GATE_BASE),
    .CLEAR_CYCLES  (CLEAR_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .clk_in            (clk_in),
    .reset_in          (reset_in),
    .enable_in         (enable_in),
    .gate_sel_in       (gate_sel_in),
    .cnt_digits_in     (cnt_digits_in),
    .cnt_ovf_in        (cnt_ovf_in),
    .cnt_reset_out     (cnt_reset_out),
    .cnt_enable_out    (cnt_enable_out),
    .digits_out        (digits_out),
    .overflow_out      (overflow_out),
    .range_out         (range_out),
    .refresh_stb_out   (refresh_stb_out),
    .streamer_ready_in (streamer_ready_in),
    .gate_active_out   (gate_active_out)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [23:0] rand_bcd();
    logic [23:0] v;
    v = '0;
    for (int i = 0; i < DIGITS_NUM; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // One full measurement, entered at a negedge where the next clock edge starts CLEAR
  // (sequencer idle, or refresh being accepted). Returns at the negedge on which ready is dropped.
  task automatic measure(input gate_sel_t sel, input logic [23:0] dig, input logic ovf,
                         input int stall, input int accept, input logic en_gate);
    int   n;
    int   exp_len;
    int   quiet;
    logic bad;

    exp_len = GATE_BASE / 100;
    for (int i = 0; i < int'(sel); i++) exp_len = exp_len * 10;
    quiet = ((stall + 1 > SETTLE_CYCLES) ? stall + 1 : SETTLE_CYCLES) + 1;

    gate_sel_in = sel;
    enable_in   = 1'b1;

    // Counter clear: previous result must stay on display, strobe already gone.
    n   = 0;
    bad = 1'b0;
    @(negedge clk_in);
    while (!cnt_enable_out && n < 100) begin
      n++;
      bad |= !cnt_reset_out | refresh_stb_out | (digits_out !== exp_digits);
      @(negedge clk_in);
    end
    check("clear_len", n, CLEAR_CYCLES);
    check("clear_state", bad, 1'b0);

    // Gate: selection changes and counter activity now must not matter.
    gate_sel_in       = sel ^ 2'd1;
    enable_in         = en_gate;
    streamer_ready_in = 1'b1;
    cnt_digits_in     = 24'($urandom);
    cnt_ovf_in        = 1'($urandom);
    n   = 0;
    bad = 1'b0;
    while (cnt_enable_out && n < 10 * GATE_BASE + 10) begin
      n++;
      bad |= cnt_reset_out | !gate_active_out | refresh_stb_out | (digits_out !== exp_digits);
      @(negedge clk_in);
    end
    check("gate_len", n, exp_len);
    check("gate_state", bad, 1'b0);

    // Settle (+ stall while the streamer is busy) and latch: counter frozen, nothing else moves.
    cnt_digits_in = dig;
    cnt_ovf_in    = ovf;
    n   = 0;
    bad = 1'b0;
    while (!refresh_stb_out && n < 200) begin
      n++;
      bad |= cnt_enable_out | cnt_reset_out | (digits_out !== exp_digits);
      streamer_ready_in = (n > stall);
      @(negedge clk_in);
    end
    check("settle_quiet_len", n, quiet);
    check("settle_state", bad, 1'b0);

    // Refresh: new snapshot visible with the strobe, held until accepted.
    exp_digits = dig;
    exp_ovf    = ovf;
    exp_range  = sel;
    check("digits", digits_out, exp_digits);
    check("overflow", overflow_out, exp_ovf);
    check("range", range_out, exp_range);
    bad = 1'b0;
    for (int j = 1; j <= accept; j++) begin
      bad |= !refresh_stb_out | cnt_enable_out | cnt_reset_out | (digits_out !== exp_digits);
      streamer_ready_in = (j < accept);
      if (j < accept) @(negedge clk_in);
    end
    check("strobe_held", bad, 1'b0);
  endtask

  task automatic expect_idle(input int cycles, input string tag);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_in);
      bad |= !cnt_reset_out | cnt_enable_out | refresh_stb_out | (digits_out !== exp_digits)
           | (overflow_out !== exp_ovf) | (range_out !== exp_range);
    end
    check(tag, bad, 1'b0);
  endtask

  initial begin
    logic bad;
    int   n;

    reset_in          = 1'b1;
    enable_in         = 1'b0;
    gate_sel_in       = 2'd2;
    cnt_digits_in     = '0;
    cnt_ovf_in        = 1'b0;
    streamer_ready_in = 1'b1;

    repeat (2) @(negedge clk_in);
    check("rst_cnt_reset", cnt_reset_out, 1'b1);
    check("rst_cnt_enable", cnt_enable_out, 1'b0);
    check("rst_strobe", refresh_stb_out, 1'b0);
    check("rst_digits", digits_out, 24'h0);
    check("rst_ovf_range", {overflow_out, range_out, gate_active_out}, 4'h0);

    // Directed: base gate with a known snapshot, then each other range, a long stall and a slow accept.
    reset_in = 1'b0;
    measure(2'd2, 24'h012345, 1'b1, 0, 1, 1'b1);
    measure(2'd0, rand_bcd(), 1'($urandom), 0, 3, 1'b1);
    measure(2'd1, rand_bcd(), 1'($urandom), 50, 2, 1'b1);
    measure(2'd3, rand_bcd(), 1'b0, 2, 1, 1'b1);

    // Randomised back-to-back measurements.
    for (int k = 0; k < 6; k++) begin
      measure(gate_sel_t'($urandom_range(0, 2)), rand_bcd(), 1'($urandom),
              int'($urandom_range(0, 7)), int'($urandom_range(1, 5)), 1'b1);
    end

    // Stop requested during the gate: result still shown, then idle.
    measure(2'd2, rand_bcd(), 1'($urandom), 1, 2, 1'b0);
    expect_idle(20, "idle_after_stop");

    // A sub-cycle enable pulse in IDLE must not start a measurement.
    @(negedge clk_in);
    #1 enable_in = 1'b1;
    #2 enable_in = 1'b0;
    expect_idle(10, "idle_enable_glitch");

    // Reset asserted in the middle of a gate clears everything immediately.
    gate_sel_in = 2'd1;
    enable_in   = 1'b1;
    n = 0;
    @(negedge clk_in);
    while (!cnt_enable_out && n < 20) begin
      n++;
      @(negedge clk_in);
    end
    check("gate_opened_before_reset", cnt_enable_out, 1'b1);
    repeat (5) @(negedge clk_in);
    #2 reset_in = 1'b1;
    #1;
    exp_digits = '0;
    exp_ovf    = 1'b0;
    exp_range  = '0;
    bad = !cnt_reset_out | cnt_enable_out | refresh_stb_out | gate_active_out;
    check("async_reset_controls", bad, 1'b0);
    check("async_reset_digits", digits_out, exp_digits);
    check("async_reset_ovf_range", {overflow_out, range_out}, {exp_ovf, exp_range});
    @(negedge clk_in);
    enable_in = 1'b0;
    reset_in  = 1'b0;
    expect_idle(5, "idle_after_reset");

    // Recovery: a fresh measurement after reset.
    measure(2'd0, rand_bcd(), 1'($urandom), 0, 1, 1'b0);
    expect_idle(5, "idle_after_recovery");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
